// File: rtl/frame_write_clip.sv
// frame_write_clip: pixel sink that clips off-frame pixels and turns the rest
// into RAM write strobes, with frame completion, overrun and pixel counters.
module frame_write_clip #(
  parameter int unsigned WIDTH        = 320,
  parameter int unsigned HEIGHT       = 320,
  parameter int unsigned FRAME_PIXELS = 102400,
  parameter logic [31:0] OFFSET       = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [63:0] data_in,
  input  logic        data_valid_in,
  output logic        WRITE,
  output logic [31:0] addr,
  output logic [31:0] datain,
  output logic        frame_done,
  output logic        busy,
  output logic        overrun,
  output logic [17:0] wr_count,
  output logic [17:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [17:0] FP = 18'(FRAME_PIXELS);

  state_e      state_q, state_d;
  logic        drain_q, drain_d;
  logic [17:0] in_cnt_q, in_cnt_d;
  logic        full;
  logic        accept;

  logic        s0_v_q;
  logic [8:0]  s0_x_q, s0_y_q;
  logic [23:0] s0_rgb_q;
  logic        s0_in;

  logic        s1_v_q, s1_in_q;
  logic [8:0]  s1_x_q, s1_y_q;
  logic [23:0] s1_rgb_q;
  logic [31:0] lin;
  logic        s2_go;

  logic        write_q;
  logic [31:0] addr_q, datain_q;
  logic        ovr_q;
  logic [17:0] wr_q, drop_q;
  logic        unused_bits;

  assign unused_bits = ^{data_in[63:50], data_in[31:24]};

  // The pixel that fills the frame stops further acceptance immediately,
  // even though the FSM only leaves RUN on the following edge.
  assign full   = (in_cnt_q == FP);
  assign accept = data_valid_in &&
                  (frame_start || (state_q == RUN && !full));

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    in_cnt_d = in_cnt_q;
    unique case (state_q)
      IDLE:  state_d = IDLE;
      RUN: begin
        drain_d = 1'b0;
        if (full) state_d = DRAIN;
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE:  state_d = IDLE;
    endcase
    if (accept) in_cnt_d = in_cnt_q + 18'd1;
    if (frame_start) begin
      state_d  = RUN;
      in_cnt_d = {17'd0, data_valid_in};
    end
  end

  assign s0_in = (32'(s0_x_q) < WIDTH) && (32'(s0_y_q) < HEIGHT);
  assign lin   = 32'(s1_x_q) + 32'(s1_y_q) * WIDTH;
  // A restart kills everything still in flight from the old frame.
  assign s2_go = s1_v_q && !frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      drain_q  <= 1'b0;
      in_cnt_q <= '0;
      s0_v_q   <= 1'b0;
      s0_x_q   <= '0;
      s0_y_q   <= '0;
      s0_rgb_q <= '0;
      s1_v_q   <= 1'b0;
      s1_in_q  <= 1'b0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s1_rgb_q <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      datain_q <= '0;
      ovr_q    <= 1'b0;
      wr_q     <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      in_cnt_q <= in_cnt_d;
      s0_v_q   <= accept;
      if (accept) begin
        s0_x_q   <= data_in[49:41];
        s0_y_q   <= data_in[40:32];
        s0_rgb_q <= data_in[23:0];
      end
      s1_v_q   <= s0_v_q && !frame_start;
      s1_in_q  <= s0_in;
      s1_x_q   <= s0_x_q;
      s1_y_q   <= s0_y_q;
      s1_rgb_q <= s0_rgb_q;
      write_q  <= s2_go && s1_in_q;
      if (s2_go && s1_in_q) begin
        addr_q   <= OFFSET | lin;
        datain_q <= {8'h00, s1_rgb_q};
      end
      if (frame_start) begin
        wr_q   <= '0;
        drop_q <= '0;
        ovr_q  <= 1'b0;
      end else begin
        if (s2_go && s1_in_q)  wr_q   <= wr_q + 18'd1;
        if (s2_go && !s1_in_q) drop_q <= drop_q + 18'd1;
        if (data_valid_in && !accept) ovr_q <= 1'b1;
      end
    end
  end

  assign WRITE      = write_q;
  assign addr       = addr_q;
  assign datain     = datain_q;
  assign frame_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign overrun    = ovr_q;
  assign wr_count   = wr_q;
  assign drop_count = drop_q;

endmodule
